muldiv_controller: RTL

Sequencer and owner of the architectural HI/LO register pair for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO. It replaces single-cycle combinational multiply/divide with an iterative 1-bit-per-cycle engine. It raises a pipeline stall while an operation is in flight and an instruction needs HI/LO or the unit. It sits beside the ALU in the execute stage. Decode drives its requests, and its HI/LO outputs feed the ALU's LO_input/HI_input.

---
 rtl/muldiv_controller.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_controller.sv
// muldiv_controller
// Sequencer for MULT/MULTU/DIV/DIVU and owner of the architectural HI/LO pair.
// Multiply is iterative shift-add. Divide is iterative restoring division.
// Each runs one bit per cycle on operand magnitudes. Signs are restored in a
// single FIXUP cycle before HI/LO are written.
//
// Optional feature macro: MULDIV_FAST_MULT_EN
//   defined   : MULT/MULTU use a single-cycle multiply (IDLE -> FIXUP).
//   undefined : iterative multiply only; no multiplier cell.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      request a new mult/div operation (ignored while busy)
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU, sampled with start
//   A          rs operand (dividend / multiplicand), also MTHI/MTLO data
//   B          rt operand (divisor / multiplier)
//   mthi/mtlo  write A into HI/LO (ignored while busy)
//   hilo_read  MFHI/MFLO in execute this cycle
//   HI_output  architectural HI register
//   LO_output  architectural LO register
//   busy       operation in flight
//   done       one-cycle pulse in the cycle after an operation writes HI/LO
//   stall      hold the pipeline: busy and a HI/LO or unit request present
module muldiv_controller #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             hilo_read,
    output logic [WIDTH-1:0] HI_output,
    output logic [WIDTH-1:0] LO_output,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Two's-complement negation used for magnitudes and sign restoration.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_done;
    logic [1:0]           r_op;
    // Multiplicand for multiply, divisor for divide, raw dividend on divide-by-zero.
    logic [WIDTH-1:0]     r_opnd;
    // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_neg_lo;
    logic                 r_neg_hi;
    logic                 r_div0;

    logic                 w_is_signed;
    logic                 w_is_div;
    logic                 w_b_zero;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_neg_lo_in;
    logic                 w_neg_hi_in;
    logic                 w_fast_mult;
    logic [2*WIDTH-1:0]   w_fast_prod;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    assign w_is_signed = ~op[0];
    assign w_is_div    = op[1];
    assign w_b_zero    = (B == {WIDTH{1'b0}});
    assign w_mag_a     = (w_is_signed && A[WIDTH-1]) ? neg_w(A) : A;
    assign w_mag_b     = (w_is_signed && B[WIDTH-1]) ? neg_w(B) : B;
    // Product and quotient are negative when operand signs differ.
    // The remainder follows the dividend.
    assign w_neg_lo_in = w_is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
    assign w_neg_hi_in = w_is_signed & A[WIDTH-1];

`ifdef MULDIV_FAST_MULT_EN
    assign w_fast_mult = 1'b1;
    assign w_fast_prod = (2*WIDTH)'(w_mag_a) * (2*WIDTH)'(w_mag_b);
`else
    assign w_fast_mult = 1'b0;
    assign w_fast_prod = {(2*WIDTH){1'b0}};
`endif

    // Shift-add step: add the multiplicand when the multiplier LSB is set, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: bring in the next dividend MSB and subtract when it fits.
    // The MSB of the (WIDTH+1)-bit difference is the borrow.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge    = ~w_div_diff[WIDTH];
    assign w_div_next  = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    assign w_prod = r_neg_lo ? neg_2w(r_acc) : r_acc;
    assign w_quot = r_neg_lo ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_hi ? neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

    // Final HI/LO values selected in the FIXUP cycle.
    always_comb begin
        w_fix_hi = {WIDTH{1'b0}};
        w_fix_lo = {WIDTH{1'b0}};
        if (r_op[1]) begin
            if (r_div0) begin
                w_fix_hi = r_opnd;
                w_fix_lo = {WIDTH{1'b1}};
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quot;
            end
        end else begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // Next-state logic for the IDLE/RUN/FIXUP sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_is_div && w_b_zero) begin
                        w_next_state = ST_FIXUP;
                    end else if (!w_is_div && w_fast_mult) begin
                        w_next_state = ST_FIXUP;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_next_state = ST_FIXUP;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_FIXUP: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand latch, iteration datapath, HI/LO ownership and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_done   <= 1'b0;
            r_op     <= 2'b00;
            r_opnd   <= {WIDTH{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIXUP);
            case (r_state)
                ST_IDLE: begin
                    // An MT write alongside start still lands now; the result overwrites it later.
                    if (mthi) r_hi <= A;
                    if (mtlo) r_lo <= A;
                    if (start) begin
                        r_op     <= op;
                        r_cnt    <= {CNT_W{1'b0}};
                        r_neg_lo <= w_neg_lo_in;
                        r_neg_hi <= w_neg_hi_in;
                        r_div0   <= w_is_div & w_b_zero;
                        if (w_is_div) begin
                            // Divide-by-zero keeps the raw dividend so HI returns A unchanged.
                            r_opnd <= w_b_zero ? A : w_mag_b;
                            r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
                        end else begin
                            r_opnd <= w_mag_a;
                            r_acc  <= w_fast_mult ? w_fast_prod : {{WIDTH{1'b0}}, w_mag_b};
                        end
                    end
                end
                ST_RUN: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CNT_ONE;
                end
                ST_FIXUP: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign HI_output = r_hi;
    assign LO_output = r_lo;
    assign done      = r_done;
    assign busy      = (r_state != ST_IDLE);
    assign stall     = busy & (hilo_read | start | mthi | mtlo);

endmodule
